// File: rtl/pcap_dma_pkg.sv
// Shared types for the position-capture DMA writer: FSM states, IRQ status
// codes, the per-cycle IRQ event vector and its priority encoder.
package pcap_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH,
    S_AERR
  } state_e;

  localparam logic [3:0] ST_NONE           = 4'd0;
  localparam logic [3:0] ST_BLOCK_FINISHED = 4'd1;
  localparam logic [3:0] ST_CAPT_FINISHED  = 4'd2;
  localparam logic [3:0] ST_TIMEOUT        = 4'd3;
  localparam logic [3:0] ST_DISARM         = 4'd4;
  localparam logic [3:0] ST_ADDR_ERROR     = 4'd5;
  localparam logic [3:0] ST_INT_DISARM     = 4'd6;

  // IRQ sources raised in one cycle, most important first
  typedef struct packed {
    logic addr_err;
    logic int_disarm;
    logic disarm;
    logic capt;
    logic blk;
    logic tmo;
  } irq_ev_t;

  // Only the highest-priority source of a cycle is reported
  function automatic logic [3:0] irq_prio(input irq_ev_t ev);
    if (ev.addr_err)   return ST_ADDR_ERROR;
    if (ev.int_disarm) return ST_INT_DISARM;
    if (ev.disarm)     return ST_DISARM;
    if (ev.capt)       return ST_CAPT_FINISHED;
    if (ev.blk)        return ST_BLOCK_FINISHED;
    if (ev.tmo)        return ST_TIMEOUT;
    return ST_NONE;
  endfunction

endpackage

// File: rtl/pcap_dma_if.sv
// Host memory write bus of the DMA writer.
//   m_waddr_o  : write byte address     (master -> slave)
//   m_wdata_o  : write data             (master -> slave)
//   m_wvalid_o : write request          (master -> slave)
//   m_wready_i : write accepted         (slave -> master)
interface pcap_dma_if;
  logic [31:0] m_waddr_o;
  logic [31:0] m_wdata_o;
  logic        m_wvalid_o;
  logic        m_wready_i;

  modport master (output m_waddr_o, output m_wdata_o, output m_wvalid_o, input m_wready_i);
  modport slave  (input m_waddr_o, input m_wdata_o, input m_wvalid_o, output m_wready_i);
endinterface

// File: rtl/pcap_dma_fifo.sv
// Synchronous DEPTH x WIDTH sample FIFO with registered occupancy.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous flush (drops all contents)
//   push/din   : write; accepted when not full or when popping in the same cycle
//   pop/dout   : read; dout shows the head word whenever not empty
//   full/empty/count : occupancy status
module pcap_dma_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  // Storage is not reset; the read side is qualified by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/pcap_dma_writer.sv
// Position-capture DMA writer: buffers capture samples and writes them
// word-by-word into host blocks whose base addresses the host posts, raising
// one IRQ (status + word count) per closed block or capture termination.
// Optional idle timeout closes a partial block: define PCAP_DMA_TIMEOUT_EN.
// Ports:
//   clk_i, reset_i                 : clock, synchronous active-high reset
//   arm_i, disarm_i, capt_end_i    : capture control pulses
//   dmaaddr_i, dmaaddr_wstb_i      : host block base address post
//   timeout_i                      : idle-cycle timeout (0 disables)
//   smpl_i, smpl_valid_i           : sample stream, no backpressure
//   m                              : host write bus (pcap_dma_if.master)
//   irq_o, irq_status_o, smpl_count_o : IRQ pulse, status code, word count
//   active_o                       : capture running or draining
module pcap_dma_writer
  import pcap_dma_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = 8192,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        arm_i,
  input  logic        disarm_i,
  input  logic        capt_end_i,
  input  logic [31:0] dmaaddr_i,
  input  logic        dmaaddr_wstb_i,
  input  logic [31:0] timeout_i,
  input  logic [31:0] smpl_i,
  input  logic        smpl_valid_i,
  pcap_dma_if.master  m,
  output logic        irq_o,
  output logic [3:0]  irq_status_o,
  output logic [31:0] smpl_count_o,
  output logic        active_o
);

  localparam int unsigned BLOCK_WORDS = BLOCK_BYTES / 4;
  localparam int unsigned FAW         = $clog2(FIFO_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] cur_q, cur_d, next_q, next_d;
  logic        cur_vld_q, cur_vld_d, next_vld_q, next_vld_d;
  logic [29:0] wcount_q, wcount_d, wcount_inc;
  logic [3:0]  fl_status_q, fl_status_d;
  irq_ev_t     ev;
  logic [3:0]  irq_status_c;
  logic [31:0] irq_count_c;
  logic        swap, done;

  logic [31:0] fifo_dout;
  logic        fifo_full, fifo_empty, fifo_push, fifo_clr;
  logic [FAW:0] fifo_cnt;
  logic        accept, blk_full, overflow, wstb_ok, tmo_fire;

  assign fifo_push  = (state_q == S_ACTIVE) && smpl_valid_i;
  assign fifo_clr   = (state_q == S_IDLE) || (state_q == S_AERR);
  assign m.m_wvalid_o = ((state_q == S_ACTIVE) || (state_q == S_FLUSH)) && !fifo_empty;
  assign m.m_waddr_o  = cur_q + {wcount_q, 2'b00};
  assign m.m_wdata_o  = m.m_wvalid_o ? fifo_dout : 32'h0;

  assign accept     = m.m_wvalid_o && m.m_wready_i;
  assign wcount_inc = wcount_q + 30'(accept);
  assign blk_full   = accept && (wcount_q == 30'(BLOCK_WORDS - 1));
  assign overflow   = fifo_push && fifo_full && !accept;
  assign wstb_ok    = dmaaddr_wstb_i && (dmaaddr_i[1:0] == 2'b00);

  pcap_dma_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk_i),
    .reset (reset_i),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (smpl_i),
    .pop   (accept),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

`ifdef PCAP_DMA_TIMEOUT_EN
  logic [31:0] tcnt_q;

  // Idle counter: ACTIVE cycles since the last accepted write
  always_ff @(posedge clk_i) begin
    if (reset_i || (state_q != S_ACTIVE) || accept || tmo_fire) tcnt_q <= '0;
    else                                                          tcnt_q <= tcnt_q + 32'd1;
  end

  assign tmo_fire = (state_q == S_ACTIVE) && (timeout_i != 32'd0) && (tcnt_q >= timeout_i) &&
                    fifo_empty && (wcount_q != 30'd0);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign tmo_fire       = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state, slot/word-count updates and IRQ sources
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cur_vld_d   = cur_vld_q;
    next_d      = next_q;
    next_vld_d  = next_vld_q;
    wcount_d    = wcount_q;
    fl_status_d = fl_status_q;
    ev          = '0;
    swap        = 1'b0;
    done        = 1'b0;

    // First empty slot; while cur is in use a post always lands in next
    if (wstb_ok) begin
      if (!cur_vld_q) begin
        cur_d     = dmaaddr_i;
        cur_vld_d = 1'b1;
      end else begin
        next_d     = dmaaddr_i;
        next_vld_d = 1'b1;
      end
    end
    if (accept) wcount_d = wcount_inc;

    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          if (cur_vld_q) state_d = S_ACTIVE;
          else           ev.addr_err = 1'b1;
        end
      end
      S_ACTIVE: begin
        swap = blk_full || tmo_fire;
        if (overflow) begin
          state_d     = S_FLUSH;
          fl_status_d = ST_INT_DISARM;
        end else if (disarm_i) begin
          state_d     = S_FLUSH;
          fl_status_d = ST_DISARM;
        end else if (capt_end_i) begin
          state_d     = S_FLUSH;
          fl_status_d = ST_CAPT_FINISHED;
        end
      end
      S_FLUSH: begin
        // A block filled by the last word is reported first; closing follows
        if (blk_full) swap = 1'b1;
        else if (fifo_empty || (accept && fifo_cnt == (FAW+1)'(1))) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_AERR: begin
        ev.addr_err = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // No follow-on block after a full/timed-out one: report, then stop
    if (swap && !next_vld_d) state_d = S_AERR;
    if (swap || done) begin
      cur_d      = next_d;
      cur_vld_d  = next_vld_d;
      next_vld_d = 1'b0;
      wcount_d   = 30'd0;
    end

    ev.blk = blk_full;
    ev.tmo = tmo_fire;
    if (done) begin
      case (fl_status_q)
        ST_INT_DISARM: ev.int_disarm = 1'b1;
        ST_DISARM:     ev.disarm     = 1'b1;
        default:       ev.capt       = 1'b1;
      endcase
    end
    if (dmaaddr_wstb_i && !wstb_ok) ev.addr_err = 1'b1;

    irq_status_c = irq_prio(ev);
    case (irq_status_c)
      ST_BLOCK_FINISHED: irq_count_c = 32'(BLOCK_WORDS);
      ST_ADDR_ERROR:     irq_count_c = 32'd0;
      default:           irq_count_c = 32'(wcount_inc);
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cur_q        <= '0;
      cur_vld_q    <= 1'b0;
      next_q       <= '0;
      next_vld_q   <= 1'b0;
      wcount_q     <= '0;
      fl_status_q  <= ST_NONE;
      irq_o        <= 1'b0;
      irq_status_o <= '0;
      smpl_count_o <= '0;
      active_o     <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      cur_vld_q   <= cur_vld_d;
      next_q      <= next_d;
      next_vld_q  <= next_vld_d;
      wcount_q    <= wcount_d;
      fl_status_q <= fl_status_d;
      irq_o       <= (ev != '0);
      if (ev != '0) begin
        irq_status_o <= irq_status_c;
        smpl_count_o <= irq_count_c;
      end
      active_o <= (state_d == S_ACTIVE) || (state_d == S_FLUSH);
    end
  end

endmodule

// File: tb/tb_pcap_dma_writer.sv
// Directed self-checking bench for pcap_dma_writer (BLOCK_BYTES=64, FIFO 16).
module tb_pcap_dma_writer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0, disarm = 1'b0, capt_end = 1'b0;
  logic [31:0] dmaaddr = '0;
  logic        wstb = 1'b0;
  logic [31:0] timeout = '0;
  logic [31:0] smpl = '0;
  logic        smpl_valid = 1'b0;
  logic        wready = 1'b0;
  logic        irq;
  logic [3:0]  irq_status;
  logic [31:0] smpl_count;
  logic        active;

  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  rec_t irq_q[$];
  rec_t wr_q[$];
  rec_t mon_r;

  pcap_dma_if bus ();
  assign bus.m_wready_i = wready;

  pcap_dma_writer #(.BLOCK_BYTES(64), .FIFO_DEPTH(16)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .arm_i          (arm),
    .disarm_i       (disarm),
    .capt_end_i     (capt_end),
    .dmaaddr_i      (dmaaddr),
    .dmaaddr_wstb_i (wstb),
    .timeout_i      (timeout),
    .smpl_i         (smpl),
    .smpl_valid_i   (smpl_valid),
    .m              (bus),
    .irq_o          (irq),
    .irq_status_o   (irq_status),
    .smpl_count_o   (smpl_count),
    .active_o       (active)
  );

  always #5 clk = ~clk;

  // Record IRQ pulses and accepted writes, sampled away from the rising edge
  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (irq === 1'b1) begin
      mon_r.a = {28'd0, irq_status}; mon_r.b = smpl_count; mon_r.cyc = cyc_n;
      irq_q.push_back(mon_r);
    end
    if (bus.m_wvalid_o === 1'b1 && wready === 1'b1) begin
      mon_r.a = bus.m_waddr_o; mon_r.b = bus.m_wdata_o; mon_r.cyc = cyc_n;
      wr_q.push_back(mon_r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [31:0] a);
    dmaaddr = a; wstb = 1'b1; step(1); wstb = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; step(1); arm = 1'b0;
  endtask

  task automatic do_capt_end();
    capt_end = 1'b1; step(1); capt_end = 1'b0;
  endtask

  task automatic send(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      smpl = base + 32'(i); smpl_valid = 1'b1; step(1);
    end
    smpl_valid = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input int idx, input logic [3:0] st, input logic [31:0] cnt);
    if (idx < irq_q.size()) begin
      chk({tag, "_status"}, irq_q[idx].a, 32'(st));
      chk({tag, "_count"}, irq_q[idx].b, cnt);
    end
  endtask

  task automatic chk_writes(input string tag, input int n, input logic [31:0] abase, input logic [31:0] dbase);
    chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < wr_q.size() && i < n; i++) begin
      chk($sformatf("%s_waddr%0d", tag, i), wr_q[i].a, abase + 32'(4 * i));
      chk($sformatf("%s_wdata%0d", tag, i), wr_q[i].b, dbase + 32'(i));
    end
  endtask

  task automatic clear_logs();
    irq_q.delete(); wr_q.delete();
  endtask

  initial begin
    // Reset state
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_status", 32'(irq_status), 32'd0);
    chk("rst_count", smpl_count, 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_wvalid", 32'(bus.m_wvalid_o), 32'd0);
    chk("rst_waddr", bus.m_waddr_o, 32'd0);
    chk("rst_wdata", bus.m_wdata_o, 32'd0);

    // Two blocks: 16 words fill the first, 4 go to the second, then capture end
    clear_logs();
    wready = 1'b1;
    post(32'h1000_0000);
    post(32'h1000_0040);
    do_arm();
    chk("t1_active", 32'(active), 32'd1);
    smpl = 32'hA000_0000; smpl_valid = 1'b1; step(1);
    chk("t1_lat_wvalid", 32'(bus.m_wvalid_o), 32'd1);
    chk("t1_lat_waddr", bus.m_waddr_o, 32'h1000_0000);
    chk("t1_lat_wdata", bus.m_wdata_o, 32'hA000_0000);
    send(19, 32'hA000_0001);
    do_capt_end();
    step(10);
    chk("t1_nirq", 32'(irq_q.size()), 32'd2);
    chk_irq("t1_irq0", 0, 4'd1, 32'd16);
    chk_irq("t1_irq1", 1, 4'd2, 32'd4);
    chk_writes("t1", 20, 32'h1000_0000, 32'hA000_0000);
    if (irq_q.size() > 0 && wr_q.size() > 15)
      chk("t1_blk_irq_lat", 32'(irq_q[0].cyc - wr_q[15].cyc), 32'd1);
    chk("t1_idle", 32'(active), 32'd0);

    // Single address: full block, then ADDR_ERROR on the missing next slot
    clear_logs();
    post(32'h2000_0000);
    do_arm();
    send(16, 32'hB000_0000);
    step(10);
    chk("t2_nirq", 32'(irq_q.size()), 32'd2);
    chk_irq("t2_irq0", 0, 4'd1, 32'd16);
    chk_irq("t2_irq1", 1, 4'd5, 32'd0);
    if (irq_q.size() > 1)
      chk("t2_aerr_lat", 32'(irq_q[1].cyc - irq_q[0].cyc), 32'd1);
    chk_writes("t2", 16, 32'h2000_0000, 32'hB000_0000);
    chk("t2_idle", 32'(active), 32'd0);

    // Misaligned post and arm without an address both give ADDR_ERROR
    clear_logs();
    post(32'h7000_0002);
    step(2);
    do_arm();
    step(4);
    chk("t2b_nirq", 32'(irq_q.size()), 32'd2);
    chk_irq("t2b_irq0", 0, 4'd5, 32'd0);
    chk_irq("t2b_irq1", 1, 4'd5, 32'd0);
    chk("t2b_idle", 32'(active), 32'd0);

    // Stalled bus, 17 samples overflow the 16-deep FIFO
    clear_logs();
    wready = 1'b0;
    post(32'h3000_0000);
    post(32'h3000_0040);
    do_arm();
    send(1, 32'hC000_0000);
    chk("t3_stall_waddr0", bus.m_waddr_o, 32'h3000_0000);
    chk("t3_stall_wdata0", bus.m_wdata_o, 32'hC000_0000);
    send(16, 32'hC000_0001);
    step(3);
    chk("t3_stall_wvalid", 32'(bus.m_wvalid_o), 32'd1);
    chk("t3_stall_waddr1", bus.m_waddr_o, 32'h3000_0000);
    chk("t3_stall_wdata1", bus.m_wdata_o, 32'hC000_0000);
    chk("t3_no_irq_stall", 32'(irq_q.size()), 32'd0);
    chk("t3_active_flush", 32'(active), 32'd1);
    wready = 1'b1;
    step(25);
    chk("t3_nirq", 32'(irq_q.size()), 32'd2);
    chk_irq("t3_irq0", 0, 4'd1, 32'd16);
    chk_irq("t3_irq1", 1, 4'd6, 32'd0);
    chk_writes("t3", 16, 32'h3000_0000, 32'hC000_0000);
    chk("t3_idle", 32'(active), 32'd0);

    // Disarm together with the 5th sample
    clear_logs();
    post(32'h4000_0000);
    do_arm();
    send(4, 32'hD000_0000);
    smpl = 32'hD000_0004; smpl_valid = 1'b1; disarm = 1'b1;
    step(1);
    smpl_valid = 1'b0; disarm = 1'b0;
    step(8);
    chk("t4_nirq", 32'(irq_q.size()), 32'd1);
    chk_irq("t4_irq0", 0, 4'd4, 32'd5);
    chk_writes("t4", 5, 32'h4000_0000, 32'hD000_0000);
    chk("t4_idle", 32'(active), 32'd0);

    // Idle timeout of 100 cycles after 3 samples
    clear_logs();
    timeout = 32'd100;
    post(32'h5000_0000);
    post(32'h5000_0040);
    do_arm();
    send(3, 32'hE000_0000);
    step(130);
`ifdef PCAP_DMA_TIMEOUT_EN
    chk("t5_nirq", 32'(irq_q.size()), 32'd1);
    chk_irq("t5_irq0", 0, 4'd3, 32'd3);
    if (irq_q.size() > 0 && wr_q.size() > 2)
      chk("t5_tmo_delay", 32'((irq_q[0].cyc - wr_q[2].cyc) >= 99 && (irq_q[0].cyc - wr_q[2].cyc) <= 102), 32'd1);
    chk_writes("t5a", 3, 32'h5000_0000, 32'hE000_0000);
    clear_logs();
    send(2, 32'hE000_0010);
    disarm = 1'b1; step(1); disarm = 1'b0;
    step(8);
    chk("t5b_nirq", 32'(irq_q.size()), 32'd1);
    chk_irq("t5b_irq0", 0, 4'd4, 32'd2);
    chk_writes("t5b", 2, 32'h5000_0040, 32'hE000_0010);
`else
    chk("t5_no_tmo", 32'(irq_q.size()), 32'd0);
    chk("t5_still_active", 32'(active), 32'd1);
    clear_logs();
    send(2, 32'hE000_0003);
    disarm = 1'b1; step(1); disarm = 1'b0;
    step(8);
    chk("t5b_nirq", 32'(irq_q.size()), 32'd1);
    chk_irq("t5b_irq0", 0, 4'd4, 32'd5);
    chk_writes("t5b", 2, 32'h5000_000C, 32'hE000_0003);
`endif
    timeout = 32'd0;

    // Reset in the middle of a stalled burst, then re-arm
    clear_logs();
    wready = 1'b0;
    post(32'h6000_0000);
    post(32'h6000_0040);
    do_arm();
    send(5, 32'hF000_0000);
    chk("t6_pre_wvalid", 32'(bus.m_wvalid_o), 32'd1);
    reset = 1'b1;
    step(1);
    chk("t6_rst_wvalid", 32'(bus.m_wvalid_o), 32'd0);
    chk("t6_rst_waddr", bus.m_waddr_o, 32'd0);
    chk("t6_rst_wdata", bus.m_wdata_o, 32'd0);
    chk("t6_rst_irq", 32'(irq), 32'd0);
    chk("t6_rst_status", 32'(irq_status), 32'd0);
    chk("t6_rst_count", smpl_count, 32'd0);
    chk("t6_rst_active", 32'(active), 32'd0);
    reset = 1'b0;
    wready = 1'b1;
    step(4);
    chk("t6_no_irq", 32'(irq_q.size()), 32'd0);
    chk("t6_no_wr", 32'(wr_q.size()), 32'd0);
    clear_logs();
    post(32'h7000_0000);
    do_arm();
    send(3, 32'h7700_0000);
    do_capt_end();
    step(8);
    chk("t6_nirq", 32'(irq_q.size()), 32'd1);
    chk_irq("t6_irq0", 0, 4'd2, 32'd3);
    chk_writes("t6", 3, 32'h7000_0000, 32'h7700_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
